// File: rtl/s1_fetch.sv
// Stage-1 fetch: drives the IMEM address, captures the synchronous-read word, applies stall/redirect.
// Optional performance counters are built when S1_FETCH_PERF_CNT_EN is defined.
module s1_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h4000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_s2,
  output logic [31:0] instruction_s2,
  output logic        valid_s2,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc;
  logic        take_redirect;
  logic        take_normal;
  logic        load_bubble;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next    = state;
    imem_addr     = fetch_pc;
    take_redirect = 1'b0;
    take_normal   = 1'b0;
    load_bubble   = 1'b0;
    case (state)
      BOOT: begin
        imem_addr   = RESET_PC;
        state_next  = RUN;
        load_bubble = 1'b1;
      end
      RUN: begin
        if (redirect_valid) begin
          imem_addr     = {redirect_pc[31:2], 2'b00};
          take_redirect = 1'b1;
          load_bubble   = 1'b1;
        end else if (!stall) begin
          imem_addr   = fetch_pc + 32'd4;
          take_normal = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  // fetch_pc always follows the presented address: it is the address whose word returns next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      pc_s2          <= 32'h0;
      instruction_s2 <= NOP_INSTR;
      valid_s2       <= 1'b0;
    end else begin
      fetch_pc <= imem_addr;
      if (load_bubble) begin
        instruction_s2 <= NOP_INSTR;
        valid_s2       <= 1'b0;
      end
      if (take_redirect) begin
        pc_s2 <= fetch_pc;
      end else if (take_normal) begin
        pc_s2          <= fetch_pc;
        instruction_s2 <= imem_rdata;
        valid_s2       <= 1'b1;
      end
    end
  end

`ifdef S1_FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (take_normal) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (load_bubble) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
`endif

endmodule
